// File: rtl/me_pkg.sv
// Shared motion-estimation constants: default current-block geometry and
// the helpers that derive row width and row-address width from it.
package me_pkg;

  localparam int IN_W_DEF   = 32;
  localparam int PACK_DEF   = 2;
  localparam int DEPTH_DEF  = 16;
  localparam int PASSES_DEF = 1;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic int out_w(input int in_w, input int pack);
    return in_w * pack;
  endfunction

  function automatic int aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/cur_pp_ram.sv
// Two-bank current-block store: address is {bank, row}, one write port and
// one read port with a registered single-cycle read.
module cur_pp_ram #(
  parameter int W  = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW:0]   rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam int N = 2 << AW;

  logic [W-1:0] mem [0:N-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cur_pp_buf.sv
// Ping-pong current-block buffer: packs input words into rows, fills two
// banks alternately and streams full banks out PASSES times each.
//
// state   | meaning
// RD_IDLE | no pass running; rd_go accepted when the read bank is full
// RD_READ | pass running; rows issued while tmr != 0, last cycle drains
module cur_pp_buf
  import me_pkg::*;
#(
  parameter  int IN_W   = IN_W_DEF,
  parameter  int PACK   = PACK_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int PASSES = PASSES_DEF,
  localparam int OUT_W  = out_w(IN_W, PACK),
  localparam int AW     = aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             rd_go,
  output logic             rd_busy,
  output logic             blk_avail,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             out_pass_last
);

  localparam int KW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [KW-1:0] K_LAST    = KW'(PACK - 1);
  localparam logic [AW-1:0] ROW_LAST  = AW'(DEPTH - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
  localparam logic [AW:0]   TMR_LOAD  = (AW + 1)'(DEPTH);

  logic [1:0]       full, full_nx;
  logic             wb, rb;
  logic [KW-1:0]    slot;
  logic [OUT_W-1:0] row_buf;
  logic             wr_pend;
  logic [AW-1:0]    wr_row;
  logic             in_acc;
  logic             blk_done;

  rd_state_e        state, state_nx;
  logic [AW:0]      tmr;
  logic [AW-1:0]    rd_row;
  logic [PW-1:0]    pass;
  logic             rd_acc, rd_en;
  logic [OUT_W-1:0] ram_q;

  assign in_ready  = !full[wb];
  assign in_acc    = in_valid & in_ready;
  assign blk_avail = full[rb];
  assign blk_done  = wr_pend && (wr_row == ROW_LAST);
  assign out_data  = out_valid ? ram_q : '0;

  // Row write lands the cycle after the last pack slot is filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      row_buf <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= in_acc && (slot == K_LAST);
      if (in_acc) begin
        row_buf[slot*IN_W +: IN_W] <= in_data;
        slot <= (slot == K_LAST) ? '0 : slot + 1'b1;
      end
    end
  end

  always_comb begin
    full_nx = full;
    if (blk_done)      full_nx[wb] = 1'b1;
    if (out_pass_last) full_nx[rb] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_row <= '0;
    end else begin
      full <= full_nx;
      if (wr_pend) wr_row <= wr_row + 1'b1;
      if (blk_done) wb <= ~wb;
      if (out_pass_last) rb <= ~rb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RD_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RD_IDLE: if (rd_acc) state_nx = RD_READ;
      RD_READ: if (tmr == '0) state_nx = RD_IDLE;
      default: state_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_acc  = 1'b0;
    rd_en   = 1'b0;
    rd_busy = 1'b0;
    case (state)
      RD_IDLE: rd_acc = rd_go && full[rb];
      RD_READ: begin
        rd_busy = 1'b1;
        rd_en   = (tmr != '0);
      end
      default: ;
    endcase
  end

  // tmr counts down the remaining rows; the extra READ cycle at zero
  // covers the one-cycle RAM latency of the final row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr           <= '0;
      rd_row        <= '0;
      pass          <= '0;
      out_valid     <= 1'b0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
      out_pass_last <= 1'b0;
    end else begin
      if (rd_acc)              tmr <= TMR_LOAD;
      else if (tmr != '0)      tmr <= tmr - 1'b1;
      if (rd_acc)              rd_row <= '0;
      else if (rd_en)          rd_row <= rd_row + 1'b1;
      out_valid     <= rd_en;
      out_first     <= rd_en && (rd_row == '0);
      out_last      <= rd_en && (rd_row == ROW_LAST);
      out_pass_last <= rd_en && (rd_row == ROW_LAST) && (pass == PASS_LAST);
      if (out_last) pass <= out_pass_last ? '0 : pass + 1'b1;
    end
  end

  cur_pp_ram #(
    .W  (OUT_W),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_pend),
    .wr_addr ({wb, wr_row}),
    .wr_data (row_buf),
    .rd_en   (rd_en),
    .rd_addr ({rb, rd_row}),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_cur_pp_buf.sv
// Directed bench for cur_pp_buf: one PASSES=1 instance and one PASSES=3
// instance sharing the write stream.
module tb_cur_pp_buf;

  localparam int DEPTH = 16;

  typedef struct {
    logic        go;
    logic [5:0]  flg;   // {busy, valid, first, last, pass_last, avail}
    logic [63:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        rd_go = 1'b0;
  logic        rd_go3 = 1'b0;

  logic        in_ready, rd_busy, blk_avail, out_valid, out_first, out_last, out_pass_last;
  logic [63:0] out_data;
  logic        in_ready3, rd_busy3, blk_avail3, out_valid3, out_first3, out_last3, out_pass_last3;
  logic [63:0] out_data3;

  int tests = 0;
  int fails = 0;

  logic        feed_en = 1'b0;
  int          feed_base = 0;
  int          feed_num = 0;
  int          fcnt = 0;

  vec_t        tab [DEPTH+3];
  logic        e_busy, e_valid, e_first, e_last, e_plast, e_avail;
  logic [63:0] e_data;
  int          err;

  always #5 clk = ~clk;

  cur_pp_buf #(.IN_W(32), .PACK(2), .DEPTH(DEPTH), .PASSES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rd_go(rd_go), .rd_busy(rd_busy), .blk_avail(blk_avail),
    .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .out_pass_last(out_pass_last)
  );

  cur_pp_buf #(.IN_W(32), .PACK(2), .DEPTH(DEPTH), .PASSES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .rd_go(rd_go3), .rd_busy(rd_busy3), .blk_avail(blk_avail3),
    .out_valid(out_valid3), .out_data(out_data3), .out_first(out_first3),
    .out_last(out_last3), .out_pass_last(out_pass_last3)
  );

  // Word stream source: offers feed_base+fcnt, advances on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (feed_en && fcnt < feed_num) begin
        in_valid = 1'b1;
        in_data  = 32'(feed_base + fcnt);
        if (in_ready) fcnt++;
      end else begin
        in_valid = 1'b0;
        if (!feed_en) fcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {in_ready, rd_busy, blk_avail, out_valid, out_first, out_last, out_pass_last, out_data},
        {1'b1, 6'b0, 64'd0});
    chk({nm, "_p3"}, {in_ready3, rd_busy3, blk_avail3, out_valid3, out_first3, out_last3,
        out_pass_last3, out_data3}, {1'b1, 6'b0, 64'd0});
  endtask

  task automatic do_reset();
    feed_en = 1'b0;
    rd_go   = 1'b0;
    rd_go3  = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_feed(input int base, input int num);
    feed_en = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    feed_base = base;
    feed_num  = num;
    feed_en   = 1'b1;
  endtask

  // One PASSES=1 pass; rows expected as {base+2r+1, base+2r}.
  task automatic run_pass(input int base, input bit chk_ready, input string nm);
    int n;
    int perr;
    logic [71:0] g, x, g0, x0;
    logic [63:0] d;
    n = 0;
    perr = 0;
    g0 = '0;
    x0 = '0;
    @(negedge clk);
    while (!(blk_avail && !rd_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_wait got=timeout exp=blk_avail", nm);
      return;
    end
    rd_go = 1'b1;
    for (int j = 0; j <= DEPTH + 1; j++) begin
      @(negedge clk);
      rd_go = 1'b0;
      d = (j >= 1 && j <= DEPTH) ? {32'(base + 2*j - 1), 32'(base + 2*j - 2)} : 64'd0;
      x = {3'b0, (j <= DEPTH), (j >= 1 && j <= DEPTH), (j == 1), (j == DEPTH), (j == DEPTH), d};
      g = {3'b0, rd_busy, out_valid, out_first, out_last, out_pass_last, out_data};
      if (g !== x && perr == 0) begin
        g0 = g;
        x0 = x;
      end
      if (g !== x) perr++;
      if (chk_ready && j == DEPTH)     chk({nm, "_ready_low"}, {71'd0, in_ready}, 72'd0);
      if (chk_ready && j == DEPTH + 1) chk({nm, "_ready_rise"}, {71'd0, in_ready}, 72'd1);
    end
    tests++;
    if (perr != 0) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (%0d bad cycles)", nm, g0, x0, perr);
    end
  endtask

  initial begin
    for (int j = 0; j < DEPTH + 3; j++) begin
      e_busy  = (j <= DEPTH);
      e_valid = (j >= 1 && j <= DEPTH);
      e_first = (j == 1);
      e_last  = (j == DEPTH);
      e_avail = (j <= DEPTH);
      tab[j].go   = (j == 5) || (j == DEPTH + 1);
      tab[j].flg  = {e_busy, e_valid, e_first, e_last, e_last, e_avail};
      tab[j].data = e_valid ? {32'(2*j - 1), 32'(2*j - 2)} : 64'd0;
    end

    #1;
    chk_reset("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single block, rd_go the cycle blk_avail rises.
    start_feed(0, 32);
    err = 0;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (!(in_ready && !blk_avail)) err++;
    end
    chk("load_ready_held", 72'(err), 72'd0);
    @(negedge clk);
    chk("avail_rise", {70'd0, blk_avail, blk_avail3}, 72'd3);
    rd_go = 1'b1;
    for (int j = 0; j < DEPTH + 3; j++) begin
      @(negedge clk);
      chk($sformatf("pass1_cyc%0d", j),
          {2'b0, rd_busy, out_valid, out_first, out_last, out_pass_last, blk_avail, out_data},
          {2'b0, tab[j].flg, tab[j].data});
      rd_go = tab[j].go;
    end
    rd_go = 1'b0;

    // PASSES=3 on the same block: rd_go on every accepted slot, then one extra.
    for (int k = 0; k < 57; k++) begin
      @(negedge clk);
      if (k / 18 < 3) begin
        e_busy  = (k % 18 >= 1);
        e_valid = (k % 18 >= 2);
        e_first = (k % 18 == 2);
        e_last  = (k % 18 == 17);
        e_plast = e_last && (k / 18 == 2);
        e_avail = 1'b1;
        e_data  = e_valid ? {32'(2*(k % 18 - 2) + 1), 32'(2*(k % 18 - 2))} : 64'd0;
      end else begin
        {e_busy, e_valid, e_first, e_last, e_plast, e_avail} = 6'b0;
        e_data = 64'd0;
      end
      chk($sformatf("p3_cyc%0d", k),
          {2'b0, rd_busy3, out_valid3, out_first3, out_last3, out_pass_last3, blk_avail3, out_data3},
          {2'b0, e_busy, e_valid, e_first, e_last, e_plast, e_avail, e_data});
      rd_go3 = (k % 18 == 0) && (k <= 54);
    end
    rd_go3 = 1'b0;

    // rd_go in the same cycle as the final row write is ignored.
    do_reset();
    start_feed(0, 32);
    repeat (32) @(negedge clk);
    @(negedge clk);
    chk("bnd_avail_at_w", {71'd0, blk_avail}, 72'd0);
    rd_go = 1'b1;
    @(negedge clk);
    chk("bnd_ignored", {69'd0, rd_busy, out_valid, blk_avail}, 72'b001);
    rd_go = 1'b1;
    @(negedge clk);
    rd_go = 1'b0;
    chk("bnd_accepted", {70'd0, rd_busy, out_valid}, 72'b10);
    @(negedge clk);
    chk("bnd_first_row", {rd_busy, out_valid, out_first, out_data[63:0]} , {3'b111, 32'd1, 32'd0});
    repeat (16) @(negedge clk);
    chk("bnd_released", {70'd0, rd_busy, blk_avail}, 72'd0);

    // Ping-pong stall: three blocks with no reads.
    do_reset();
    start_feed(0, 96);
    err = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (in_ready !== (k < 65)) err++;
    end
    chk("stall_ready", 72'(err), 72'd0);
    run_pass(0, 1'b1, "stall_b0");
    run_pass(32, 1'b0, "stall_b1");
    run_pass(64, 1'b0, "stall_b3");

    // Reset in the middle of a pass, at row 7.
    do_reset();
    start_feed(0, 32);
    err = 0;
    @(negedge clk);
    while (!blk_avail && err < 100) begin
      @(negedge clk);
      err++;
    end
    chk("mid_pass_wait", {71'd0, blk_avail}, 72'd1);
    rd_go = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      rd_go = 1'b0;
    end
    chk("mid_pass_row7", {out_valid, out_data}, {1'b1, 32'd15, 32'd14});
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid_pass");
    @(negedge clk);
    rst_n = 1'b1;
    start_feed(100, 32);
    run_pass(100, 1'b0, "after_pass_rst");

    // Reset in the middle of a load, after word 13.
    do_reset();
    start_feed(0, 32);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2;
    feed_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_reset("rst_mid_load");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_feed(200, 32);
    run_pass(200, 1'b0, "after_load_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
